// File: rtl/regfile_dump_reader_if.sv
// Output stream of the register-file dump reader: one word per valid/ready handshake,
// tagged with the register index and a last-word marker.
interface regfile_dump_reader_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [ADDR_W-1:0] out_index;
    logic              out_last;

    modport master (
        output out_valid,
        input  out_ready,
        output out_data,
        output out_index,
        output out_last
    );

    modport slave (
        input  out_valid,
        output out_ready,
        input  out_data,
        input  out_index,
        input  out_last
    );
endinterface

// File: rtl/regfile_dump_reader.sv
// Walks register addresses 0..NUM_REGS-1 through a combinational read port and streams each value.
// Optional feature macro REGDUMP_CHECKSUM_EN appends an XOR checksum word after the last register.
module regfile_dump_reader #(
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_W-1:0]     rf_addr,
    input  logic [DATA_W-1:0]     rf_rdata,
    regfile_dump_reader_if.master out
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

`ifdef REGDUMP_CHECKSUM_EN
    typedef enum logic [2:0] {S_IDLE, S_READ, S_SEND, S_FIN, S_CSUM} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_READ, S_SEND, S_FIN} state_t;
`endif

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic [ADDR_W-1:0]   rf_addr_q, rf_addr_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                valid_q, valid_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [ADDR_W-1:0]   index_q, index_d;
    logic                last_q, last_d;
`ifdef REGDUMP_CHECKSUM_EN
    logic [DATA_W-1:0]   csum_q, csum_d;
`endif

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        rf_addr_d = rf_addr_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        valid_d   = valid_q;
        data_d    = data_q;
        index_d   = index_q;
        last_d    = last_q;
`ifdef REGDUMP_CHECKSUM_EN
        csum_d    = csum_q;
`endif
        case (state_q)
            // A start coinciding with the done pulse is dropped; only a quiet IDLE accepts it.
            S_IDLE: begin
                if (start && !done_q) begin
                    idx_d     = '0;
                    rf_addr_d = '0;
                    busy_d    = 1'b1;
                    state_d   = S_READ;
`ifdef REGDUMP_CHECKSUM_EN
                    csum_d    = '0;
`endif
                end
            end
            S_READ: begin
                data_d  = rf_rdata;
                index_d = idx_q;
                valid_d = 1'b1;
                state_d = S_SEND;
`ifdef REGDUMP_CHECKSUM_EN
                last_d  = 1'b0;
                csum_d  = csum_q ^ rf_rdata;
`else
                last_d  = (idx_q == LAST_IDX);
`endif
            end
            S_SEND: begin
                if (valid_q && out.out_ready) begin
                    valid_d = 1'b0;
                    if (last_q) begin
                        state_d = S_FIN;
`ifdef REGDUMP_CHECKSUM_EN
                    end else if (idx_q == LAST_IDX) begin
                        state_d = S_CSUM;
`endif
                    end else begin
                        idx_d     = idx_q + 1'b1;
                        rf_addr_d = idx_q + 1'b1;
                        state_d   = S_READ;
                    end
                end
            end
`ifdef REGDUMP_CHECKSUM_EN
            S_CSUM: begin
                data_d  = csum_q;
                index_d = '0;
                last_d  = 1'b1;
                valid_d = 1'b1;
                state_d = S_SEND;
            end
`endif
            S_FIN: begin
                done_d    = 1'b1;
                busy_d    = 1'b0;
                rf_addr_d = '0;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            rf_addr_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            valid_q   <= 1'b0;
            data_q    <= '0;
            index_q   <= '0;
            last_q    <= 1'b0;
`ifdef REGDUMP_CHECKSUM_EN
            csum_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            rf_addr_q <= rf_addr_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            valid_q   <= valid_d;
            data_q    <= data_d;
            index_q   <= index_d;
            last_q    <= last_d;
`ifdef REGDUMP_CHECKSUM_EN
            csum_q    <= csum_d;
`endif
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign rf_addr       = rf_addr_q;
    assign out.out_valid = valid_q;
    assign out.out_data  = data_q;
    assign out.out_index = index_q;
    assign out.out_last  = last_q;

endmodule
